cpc_rom_loader: RTL and testbench

// Upstream stage of the SDRAM boot write port: turns the hps_io ioctl byte stream (system ROM set or
// "*.eXX" expansion ROM) into ce_ref-paced SDRAM writes (boot_wr/boot_a/boot_bank/boot_dout).
// It also throttles hps_io via ioctl_wait and maintains the 256-bit rom_map of populated expansion pages.
// Its outputs drive the sdram port muxes while the core is held in download reset.

---
 rtl/cpc_rom_loader.sv | 181 ++++++++++++++++++
 tb/tb_cpc_rom_loader.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpc_rom_loader.sv
`default_nettype none
// ============================================================================
// Module  : cpc_rom_loader
// Brief   : Turns the hps_io ioctl byte stream into ce_ref-paced SDRAM boot
//           writes and tracks which expansion ROM pages have been loaded.
// Rev     : 1.0  initial release
// ============================================================================
module cpc_rom_loader #(
    parameter logic [8:0] MF2_PAGE = 9'h1FF,
    parameter logic [8:0] BAD_PAGE = 9'h1EE
) (
    input  logic         i_clk_sys,
    input  logic         i_reset,
    input  logic         i_ce_ref,
    input  logic         i_ioctl_download,
    input  logic         i_ioctl_wr,
    input  logic [24:0]  i_ioctl_addr,
    input  logic [7:0]   i_ioctl_dout,
    input  logic [7:0]   i_ioctl_index,
    input  logic [15:0]  i_ioctl_file_ext,
    output logic         o_ioctl_wait,
    output logic         o_boot_wr,
    output logic [22:0]  o_boot_a,
    output logic [1:0]   o_boot_bank,
    output logic [7:0]   o_boot_dout,
    output logic [255:0] o_rom_map,
    output logic         o_busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    state_t         r_state;
    logic [8:0]     r_page;
    logic           r_combo;
    logic           r_dl_d;
    logic           r_ioctl_wait;
    logic           r_boot_wr;
    logic [22:0]    r_boot_a;
    logic [1:0]     r_boot_bank;
    logic [7:0]     r_boot_dout;
    logic [255:0]   r_rom_map;
    logic           r_busy;

    logic [4:0]     w_hi;
    logic [4:0]     w_lo;
    logic [8:0]     w_ext_page;
    logic           w_ext_combo;
    logic [10:0]    w_blk;
    logic           w_blk_ok;
    logic [8:0]     w_sys_page;
    logic [7:0]     w_pg_sum;
    logic [22:0]    w_next_a;
    logic [1:0]     w_next_bank;
    logic           w_accept;
    logic           w_dual;

    // Upper-case hex digit to nibble; bit 4 flags a valid character.
    function automatic logic [4:0] hex_nib(input logic [7:0] c);
        if (c >= 8'h30 && c <= 8'h39)
            return {1'b1, c[3:0]};
        else if (c >= 8'h41 && c <= 8'h46)
            return {1'b1, 4'(c[3:0] + 4'd9)};
        else
            return 5'd0;
    endfunction

    assign w_hi     = hex_nib(i_ioctl_file_ext[15:8]);
    assign w_lo     = hex_nib(i_ioctl_file_ext[7:0]);
    assign w_blk    = i_ioctl_addr[24:14];
    assign w_blk_ok = (w_blk[10:3] == 8'd0);
    assign w_pg_sum = r_page[7:0] + i_ioctl_addr[21:14];
    assign w_accept = i_ioctl_wr && i_ioctl_download &&
                      (i_ioctl_index != 8'd0 || w_blk_ok);
    assign w_dual   = (i_ioctl_index[7:6] == 2'b01 || i_ioctl_index[5:0] != 6'd0) &&
                      (r_boot_bank == 2'd0);

    // "ZZ"/"Z0" select expansion page 0; any other non-hex pair is malformed.
    always_comb begin
        w_ext_page  = BAD_PAGE;
        w_ext_combo = 1'b0;
        if (i_ioctl_file_ext == 16'h5A5A) begin
            w_ext_page = 9'h100;
        end else if (i_ioctl_file_ext == 16'h5A30) begin
            w_ext_page  = 9'h100;
            w_ext_combo = 1'b1;
        end else if (w_hi[4] && w_lo[4]) begin
            w_ext_page = {1'b1, w_hi[3:0], w_lo[3:0]};
        end
    end

    always_comb begin
        case (w_blk[1:0])
            2'd0:    w_sys_page = 9'h000;
            2'd1:    w_sys_page = 9'h100;
            2'd2:    w_sys_page = 9'h107;
            default: w_sys_page = MF2_PAGE;
        endcase
        if (i_ioctl_index != 8'd0) begin
            w_next_a    = {r_page[8], w_pg_sum, i_ioctl_addr[13:0]};
            w_next_bank = {1'b0, &i_ioctl_index[7:6]};
        end else begin
            w_next_a    = {w_sys_page, i_ioctl_addr[13:0]};
            w_next_bank = {1'b0, w_blk[2]};
        end
    end

    always_ff @(posedge i_clk_sys) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_page       <= 9'd0;
            r_combo      <= 1'b0;
            r_dl_d       <= 1'b0;
            r_ioctl_wait <= 1'b0;
            r_boot_wr    <= 1'b0;
            r_boot_a     <= 23'd0;
            r_boot_bank  <= 2'd0;
            r_boot_dout  <= 8'd0;
            r_rom_map    <= '0;
            r_busy       <= 1'b0;
        end else begin
            r_dl_d <= i_ioctl_download;
            if (i_ioctl_download && !r_dl_d && i_ioctl_index != 8'd0) begin
                r_page  <= w_ext_page;
                r_combo <= w_ext_combo;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_boot_dout  <= i_ioctl_dout;
                        r_boot_a     <= w_next_a;
                        r_boot_bank  <= w_next_bank;
                        r_ioctl_wait <= 1'b1;
                        r_busy       <= 1'b1;
                        r_state      <= ST_ARM;
                    end
                end
                ST_ARM: begin
                    if (i_ce_ref) begin
                        r_boot_wr <= 1'b1;
                        r_state   <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (i_ce_ref) begin
                        r_boot_wr <= 1'b0;
                        if (w_dual) begin
                            // Same byte is mirrored into bank 1.
                            r_boot_bank <= 2'd1;
                            r_state     <= ST_ARM;
                        end else begin
                            r_ioctl_wait <= 1'b0;
                            r_busy       <= 1'b0;
                            r_state      <= ST_IDLE;
                            if (r_boot_a[22])
                                r_rom_map[r_boot_a[21:14]] <= 1'b1;
                            if (r_combo && r_boot_a[13:0] == 14'h3FFF) begin
                                r_page  <= MF2_PAGE;
                                r_combo <= 1'b0;
                            end
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_ioctl_wait = r_ioctl_wait;
    assign o_boot_wr    = r_boot_wr;
    assign o_boot_a     = r_boot_a;
    assign o_boot_bank  = r_boot_bank;
    assign o_boot_dout  = r_boot_dout;
    assign o_rom_map    = r_rom_map;
    assign o_busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_cpc_rom_loader.sv
`default_nettype none
// ============================================================================
// Module  : tb_cpc_rom_loader
// Brief   : Directed and randomized byte streams for cpc_rom_loader, checked
//           against a page/bank/rom_map model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_cpc_rom_loader;

    logic         clk  = 1'b0;
    logic         rst  = 1'b1;
    logic         ce   = 1'b0;
    logic         dl   = 1'b0;
    logic         wr   = 1'b0;
    logic [24:0]  addr = '0;
    logic [7:0]   din  = '0;
    logic [7:0]   idx  = '0;
    logic [15:0]  ext  = '0;
    logic         ioctl_wait;
    logic         boot_wr;
    logic [22:0]  boot_a;
    logic [1:0]   boot_bank;
    logic [7:0]   boot_dout;
    logic [255:0] rom_map;
    logic         busy;

    int           n_cmp = 0;
    int           n_err = 0;
    int           ce_cnt = 0;
    logic [32:0]  wq[$];
    logic         mon_prev = 1'b0;
    logic         mon_ce;
    logic         mon_rst;

    int           m_page = 0;
    bit           m_combo = 1'b0;
    logic [255:0] exp_map = '0;
    int           sys_pages[4] = '{0, 'h100, 'h107, 'h1FF};

    cpc_rom_loader dut (
        .i_clk_sys        (clk),
        .i_reset          (rst),
        .i_ce_ref         (ce),
        .i_ioctl_download (dl),
        .i_ioctl_wr       (wr),
        .i_ioctl_addr     (addr),
        .i_ioctl_dout     (din),
        .i_ioctl_index    (idx),
        .i_ioctl_file_ext (ext),
        .o_ioctl_wait     (ioctl_wait),
        .o_boot_wr        (boot_wr),
        .o_boot_a         (boot_a),
        .o_boot_bank      (boot_bank),
        .o_boot_dout      (boot_dout),
        .o_rom_map        (rom_map),
        .o_busy           (busy)
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(negedge clk);
        ce_cnt = (ce_cnt + 1) % 16;
        ce = (ce_cnt == 0);
    end

    // Records every write request and checks that boot_wr only moves on ce_ref (or reset).
    initial forever begin
        @(posedge clk);
        mon_ce  = ce;
        mon_rst = rst;
        #1;
        if (boot_wr !== mon_prev) begin
            n_cmp++;
            if (!(mon_ce || mon_rst)) begin
                n_err++;
                $display("FAIL boot_wr_pacing: boot_wr moved to %b, required no change without ce_ref", boot_wr);
            end
            if (boot_wr === 1'b1) wq.push_back({boot_bank, boot_a, boot_dout});
            mon_prev = boot_wr;
        end
    end

    function automatic int hexval(input logic [7:0] c);
        string s;
        s = "0123456789ABCDEF";
        for (int i = 0; i < 16; i++) if (s[i] == c) return i;
        return -1;
    endfunction

    function automatic void decode_ext(input logic [15:0] e);
        int hi, lo;
        hi = hexval(e[15:8]);
        lo = hexval(e[7:0]);
        m_combo = 1'b0;
        if (e == "ZZ") m_page = 'h100;
        else if (e == "Z0") begin m_page = 'h100; m_combo = 1'b1; end
        else if (hi >= 0 && lo >= 0) m_page = 256 + hi * 16 + lo;
        else m_page = 'h1EE;
    endfunction

    task automatic model_byte(input logic [7:0] ix, input logic [24:0] a, input logic [7:0] d,
                              output int n, output logic [32:0] w0, output logic [32:0] w1,
                              output bit acc);
        int pg, bank, blk, off_i, hi_i;
        logic [22:0] ea;
        blk   = int'(a[24:14]);
        hi_i  = int'(a[21:14]);
        off_i = int'(a[13:0]);
        acc = 1'b1; n = 0; w0 = '0; w1 = '0;
        if (ix == 8'd0) begin
            if (blk > 7) begin acc = 1'b0; return; end
            pg = sys_pages[blk % 4];
            bank = blk / 4;
        end else begin
            pg = (m_page / 256) * 256 + ((m_page % 256) + hi_i) % 256;
            bank = (ix[7:6] == 2'b11) ? 1 : 0;
        end
        ea = 23'(pg * 16384 + off_i);
        w0 = {2'(bank), ea, d};
        w1 = {2'd1, ea, d};
        n = ((ix[7:6] == 2'b01 || ix[5:0] != 6'd0) && bank == 0) ? 2 : 1;
        if (pg >= 256) exp_map[pg % 256] = 1'b1;
        if (m_combo && off_i == 16383) begin m_page = 'h1FF; m_combo = 1'b0; end
    endtask

    task automatic start_dl(input logic [7:0] ix, input logic [15:0] e);
        @(negedge clk); dl = 1'b0; idx = ix; ext = e;
        @(negedge clk); dl = 1'b1;
        @(negedge clk);
        if (ix != 8'd0) decode_ext(e);
    endtask

    task automatic wait_idle(output bit to);
        to = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (!busy && !ioctl_wait) begin to = 1'b0; break; end
            @(negedge clk);
        end
    endtask

    task automatic send_byte(input logic [24:0] a, input logic [7:0] d, output bit ws, output bit to);
        wq.delete();
        @(negedge clk); addr = a; din = d; wr = 1'b1;
        @(negedge clk); wr = 1'b0; ws = ioctl_wait;
        wait_idle(to);
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1; wr = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_page = 0; m_combo = 1'b0; exp_map = '0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++; if (boot_wr !== 1'b0) begin n_err++; $display("FAIL rst_boot_wr: got %b required 0", boot_wr); end
        n_cmp++; if (ioctl_wait !== 1'b0) begin n_err++; $display("FAIL rst_wait: got %b required 0", ioctl_wait); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b required 0", busy); end
        n_cmp++; if ({boot_a, boot_bank, boot_dout} !== 33'd0) begin n_err++;
            $display("FAIL rst_addr: got a=%h bank=%h dout=%h required 0", boot_a, boot_bank, boot_dout); end
        n_cmp++; if (rom_map !== 256'd0) begin n_err++; $display("FAIL rst_rom_map: got %h required 0", rom_map); end
        rst = 1'b0;
    endtask

    task automatic test_ext_3a();
        bit ws, to;
        start_dl(8'h41, "3A");
        send_byte(25'h0123, 8'h5A, ws, to);
        n_cmp++; if (ws !== 1'b1 || to) begin n_err++; $display("FAIL e3a_handshake: wait=%b timeout=%b required 1/0", ws, to); end
        n_cmp++; if (wq.size() != 2) begin n_err++; $display("FAIL e3a_count: got %0d writes required 2", wq.size()); end
        else begin
            n_cmp++; if (wq[0] !== {2'd0, 23'h4E8123, 8'h5A}) begin n_err++; $display("FAIL e3a_w0: got %h required %h", wq[0], {2'd0, 23'h4E8123, 8'h5A}); end
            n_cmp++; if (wq[1] !== {2'd1, 23'h4E8123, 8'h5A}) begin n_err++; $display("FAIL e3a_w1: got %h required %h", wq[1], {2'd1, 23'h4E8123, 8'h5A}); end
        end
        n_cmp++; if (rom_map[8'h3A] !== 1'b1) begin n_err++; $display("FAIL e3a_map: got %b required 1", rom_map[8'h3A]); end
        n_cmp++; if (ioctl_wait !== 1'b0) begin n_err++; $display("FAIL e3a_wait_low: got %b required 0", ioctl_wait); end
    endtask

    task automatic test_sysrom();
        bit ws, to;
        start_dl(8'h00, 16'h0000);
        send_byte(25'h10000, 8'hC3, ws, to);
        n_cmp++; if (ws !== 1'b1 || to) begin n_err++; $display("FAIL sys_handshake: wait=%b timeout=%b required 1/0", ws, to); end
        n_cmp++; if (wq.size() != 1) begin n_err++; $display("FAIL sys_count: got %0d writes required 1", wq.size()); end
        else begin
            n_cmp++; if (wq[0] !== {2'd1, 23'h000000, 8'hC3}) begin n_err++; $display("FAIL sys_w0: got %h required %h", wq[0], {2'd1, 23'h0, 8'hC3}); end
        end
        send_byte(25'h20000, 8'h44, ws, to);
        n_cmp++; if (ws !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL sys_drop_wait: wait=%b busy=%b required 0/0", ws, busy); end
        repeat (40) @(negedge clk);
        n_cmp++; if (wq.size() != 0) begin n_err++; $display("FAIL sys_drop_count: got %0d writes required 0", wq.size()); end
    endtask

    task automatic test_combo();
        bit ws, to;
        logic [22:0] exp_a[3] = '{23'h400000, 23'h403FFF, 23'h7FC001};
        logic [24:0] offs[3]  = '{25'h0000, 25'h3FFF, 25'h0001};
        start_dl(8'h41, "Z0");
        for (int i = 0; i < 3; i++) begin
            send_byte(offs[i], 8'(8'h10 + i), ws, to);
            n_cmp++; if (wq.size() != 2 || to) begin n_err++; $display("FAIL combo_count[%0d]: got %0d writes timeout=%b required 2/0", i, wq.size(), to); end
            else begin
                n_cmp++; if (wq[0] !== {2'd0, exp_a[i], 8'(8'h10 + i)}) begin n_err++;
                    $display("FAIL combo_w0[%0d]: got %h required %h", i, wq[0], {2'd0, exp_a[i], 8'(8'h10 + i)}); end
            end
        end
        n_cmp++; if (rom_map[0] !== 1'b1 || rom_map[255] !== 1'b1) begin n_err++;
            $display("FAIL combo_map: got map[0]=%b map[FF]=%b required 1/1", rom_map[0], rom_map[255]); end
    endtask

    task automatic test_bad_ext();
        bit ws, to;
        start_dl(8'h41, "g1");
        send_byte(25'h0000, 8'hA5, ws, to);
        n_cmp++; if (wq.size() < 1 || wq[0] !== {2'd0, 23'h7B8000, 8'hA5}) begin n_err++;
            $display("FAIL bad_ext_w0: got %0d writes first %h required %h", wq.size(), (wq.size() > 0) ? wq[0] : 33'd0, {2'd0, 23'h7B8000, 8'hA5}); end
        n_cmp++; if (rom_map[8'hEE] !== 1'b1) begin n_err++; $display("FAIL bad_ext_map: got %b required 1", rom_map[8'hEE]); end
        start_dl(8'h41, "FF");
        send_byte(25'h4000, 8'h3C, ws, to);
        n_cmp++; if (wq.size() < 1 || wq[0] !== {2'd0, 23'h400000, 8'h3C}) begin n_err++;
            $display("FAIL wrap_w0: got %0d writes first %h required %h", wq.size(), (wq.size() > 0) ? wq[0] : 33'd0, {2'd0, 23'h400000, 8'h3C}); end
    endtask

    task automatic test_back_to_back();
        bit ws, to;
        start_dl(8'hC0, "05");
        wq.delete();
        @(negedge clk); addr = 25'h0010; din = 8'h11; wr = 1'b1;
        @(negedge clk); wr = 1'b0;
        repeat (3) @(negedge clk);
        addr = 25'h0020; din = 8'h22; wr = 1'b1;
        @(negedge clk); wr = 1'b0;
        wait_idle(to);
        n_cmp++; if (wq.size() != 1 || to) begin n_err++; $display("FAIL b2b_count: got %0d writes timeout=%b required 1/0", wq.size(), to); end
        else begin
            n_cmp++; if (wq[0] !== {2'd1, 23'h414010, 8'h11}) begin n_err++; $display("FAIL b2b_w0: got %h required %h", wq[0], {2'd1, 23'h414010, 8'h11}); end
        end
        send_byte(25'h4021, 8'h33, ws, to);
        n_cmp++; if (wq.size() != 1 || wq[0] !== {2'd1, 23'h418021, 8'h33}) begin n_err++;
            $display("FAIL b2b_second: got %0d writes first %h required %h", wq.size(), (wq.size() > 0) ? wq[0] : 33'd0, {2'd1, 23'h418021, 8'h33}); end
    endtask

    task automatic test_download_fall();
        bit to;
        start_dl(8'h01, "7C");
        wq.delete();
        @(negedge clk); addr = 25'h0005; din = 8'h99; wr = 1'b1;
        @(negedge clk); wr = 1'b0; dl = 1'b0;
        wait_idle(to);
        n_cmp++; if (wq.size() != 2 || to) begin n_err++; $display("FAIL dlfall_count: got %0d writes timeout=%b required 2/0", wq.size(), to); end
        else begin
            n_cmp++; if (wq[1] !== {2'd1, 23'h5F0005, 8'h99}) begin n_err++; $display("FAIL dlfall_w1: got %h required %h", wq[1], {2'd1, 23'h5F0005, 8'h99}); end
        end
        n_cmp++; if (rom_map[8'h7C] !== 1'b1) begin n_err++; $display("FAIL dlfall_map: got %b required 1", rom_map[8'h7C]); end
    endtask

    task automatic test_reset_mid_write();
        bit seen;
        start_dl(8'h41, "12");
        @(negedge clk); addr = 25'h0000; din = 8'h77; wr = 1'b1;
        @(negedge clk); wr = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (boot_wr === 1'b1) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        n_cmp++; if (!seen) begin n_err++; $display("FAIL rmid_reach_write: boot_wr got 0 required 1 within 100 clk"); end
        wq.delete();
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (boot_wr !== 1'b0 || ioctl_wait !== 1'b0) begin n_err++;
            $display("FAIL rmid_outputs: boot_wr=%b wait=%b required 0/0", boot_wr, ioctl_wait); end
        rst = 1'b0;
        m_page = 0; m_combo = 1'b0; exp_map = '0;
        repeat (100) @(negedge clk);
        n_cmp++; if (wq.size() != 0 || rom_map !== 256'd0) begin n_err++;
            $display("FAIL rmid_after: got %0d writes map=%h required 0 writes, map 0", wq.size(), rom_map); end
    endtask

    task automatic test_random();
        logic [7:0]  ixs[6] = '{8'h00, 8'h41, 8'h01, 8'hC0, 8'h80, 8'h40};
        string       pool;
        logic [7:0]  ix;
        logic [15:0] e;
        logic [10:0] blk;
        logic [13:0] off;
        logic [24:0] a;
        logic [7:0]  d;
        logic [32:0] w0, w1, ew;
        int          n, r;
        bit          acc, ws, to;
        pool = "0123456789ABCDEFZga";
        do_reset();
        for (int dlc = 0; dlc < 8; dlc++) begin
            ix = ixs[$urandom_range(0, 5)];
            r = int'($urandom_range(0, 5));
            if (r == 0) e = "Z0";
            else if (r == 1) e = "ZZ";
            else e = {pool[$urandom_range(0, 18)], pool[$urandom_range(0, 18)]};
            start_dl(ix, e);
            for (int b = 0; b < 8; b++) begin
                blk = (ix == 8'd0) ? 11'($urandom_range(0, 9)) : 11'($urandom_range(0, 2047));
                off = ($urandom_range(0, 3) == 0) ? 14'h3FFF : 14'($urandom_range(0, 16383));
                a = {blk, off};
                d = 8'($urandom_range(0, 255));
                model_byte(ix, a, d, n, w0, w1, acc);
                send_byte(a, d, ws, to);
                n_cmp++; if (ws !== acc || to) begin n_err++;
                    $display("FAIL rnd_accept: ix=%h addr=%h wait=%b timeout=%b required %b/0", ix, a, ws, to, acc); end
                n_cmp++; if (wq.size() != n) begin n_err++;
                    $display("FAIL rnd_count: ix=%h ext=%h addr=%h got %0d writes required %0d", ix, e, a, wq.size(), n); end
                for (int k = 0; k < n && k < wq.size(); k++) begin
                    ew = (k == 0) ? w0 : w1;
                    n_cmp++; if (wq[k] !== ew) begin n_err++;
                        $display("FAIL rnd_write[%0d]: ix=%h ext=%h addr=%h got %h required %h", k, ix, e, a, wq[k], ew); end
                end
                n_cmp++; if (rom_map !== exp_map) begin n_err++;
                    $display("FAIL rnd_rom_map: got %h required %h", rom_map, exp_map); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_ext_3a();
        test_sysrom();
        test_combo();
        test_bad_ext();
        test_back_to_back();
        test_download_fall();
        test_reset_mid_write();
        test_random();
        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
